weighted_sum_serial: RTL

Parametrised, time-multiplexed successor to the parallel weighted-sum datapath in single-layer-perceptron. It accepts an N-element signed input vector `x`, a weight vector `w` and a bias through a valid/ready handshake. It accumulates `bias + Σ x[i]*w[i]` through one shared multiplier over N cycles, with per-step saturation. It presents the sum, a step-activation `fire` bit and a sticky `overflow` flag through an output valid/ready handshake. This block is the neuron core for perceptron layers that are too wide for one DSP per input.

---
 rtl/weighted_sum_serial.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/weighted_sum_serial.sv
// Serial neuron core: bias + sum(x[i]*w[i]) through one shared multiplier,
// saturating each step, with valid/ready handshakes on both sides.
module weighted_sum_serial #(
    parameter int unsigned N     = 2,
    parameter int unsigned DW    = 18,
    parameter int unsigned ACC_W = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW*N-1:0]   x,
    input  logic [DW*N-1:0]   w,
    input  logic [ACC_W-1:0]  bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              fire,
    output logic              overflow
);

    localparam int unsigned VW    = DW * N;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned SW    = ACC_W + 1;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [VW-1:0]            x_q, x_d;
    logic [VW-1:0]            w_q, w_d;
    logic                     ovf_q, ovf_d;
    logic [ACC_W-1:0]         sum_q, sum_d;
    logic                     fire_q, fire_d;
    logic                     overflow_q, overflow_d;

    logic signed [DW-1:0]     x_sel;
    logic signed [DW-1:0]     w_sel;
    logic signed [PW-1:0]     prod;
    logic signed [SW-1:0]     step_sum;
    logic [ACC_W-1:0]         step_sat;
    logic                     step_clamp;
    logic                     accept;

    // Handshake decode from registered state; out_ready->in_ready is the only comb path
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    assign sum      = sum_q;
    assign fire     = fire_q;
    assign overflow = overflow_q;

    // Select the operand pair for the current step
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                x_sel = x_q[DW*i +: DW];
                w_sel = w_q[DW*i +: DW];
            end
        end
    end

    // One extra bit of headroom: the top two bits disagree exactly when the step overflows
    always_comb begin
        prod       = PW'(x_sel) * PW'(w_sel);
        step_sum   = SW'(acc_q) + SW'(prod);
        step_clamp = step_sum[SW-1] ^ step_sum[SW-2];
        if (step_clamp) begin
            step_sat = step_sum[SW-1] ? ACC_MIN : ACC_MAX;
        end else begin
            step_sat = step_sum[ACC_W-1:0];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        x_d        = x_q;
        w_d        = w_q;
        ovf_d      = ovf_q;
        sum_d      = sum_q;
        fire_d     = fire_q;
        overflow_d = overflow_q;

        case (state_q)
            MAC: begin
                acc_d = step_sat;
                ovf_d = ovf_q | step_clamp;
                if (idx_q == IDX_LAST) begin
                    sum_d      = step_sat;
                    fire_d     = ~step_sat[ACC_W-1] & (|step_sat);
                    overflow_d = ovf_q | step_clamp;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept only happens in IDLE or DONE, so it never collides with a MAC step
        if (accept) begin
            x_d     = x;
            w_d     = w;
            acc_d   = bias;
            idx_d   = '0;
            ovf_d   = 1'b0;
            state_d = MAC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            ovf_q      <= 1'b0;
            sum_q      <= '0;
            fire_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            w_q        <= w_d;
            ovf_q      <= ovf_d;
            sum_q      <= sum_d;
            fire_q     <= fire_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
